// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter:
//   arb_state_t   - arbiter FSM state encoding (IDLE, START, WAIT_DONE, GAP)
//   DEFAULT_DBITS - default number of data bits per UART frame
//   rotate_index  - round-robin helper: index reached by stepping 'step'
//                   places past 'base' in a ring of 'n' requesters
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

  localparam int DEFAULT_DBITS = 8;

  function automatic int unsigned rotate_index(input int unsigned base,
                                               input int unsigned step,
                                               input int unsigned n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker. Searches last_grant+1, last_grant+2, ...
// (wrapping modulo NREQ) for the first requester with its req bit set.
// When lock_en is high only lock_owner is eligible.
// Ports:
//   req        in  NREQ  request mask
//   last_grant in  IDW   most recently granted index (lowest priority now)
//   lock_en    in  1     restrict the search to lock_owner
//   lock_owner in  IDW   index of the requester holding the lock
//   grant      out NREQ  one-hot winner (all zero when nobody qualifies)
//   grant_idx  out IDW   index of the winner
//   found      out 1     a winner exists
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  input  logic            lock_en,
  input  logic [IDW-1:0]  lock_owner,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            found
);

  logic [IDW-1:0] cand;

  // The candidate exactly at last_grant is visited last (step NREQ), so the
  // previous winner only wins again when nobody else is asking.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'(rotate_index(32'(last_grant), 32'(k), 32'(NREQ)));
      if (!found && req[cand] && (!lock_en || (cand == lock_owner))) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx among NREQ byte requesters. A byte is accepted over a
// valid/ready handshake in IDLE, tx_start pulses the cycle after, the byte is
// held on tx_din until tx_done_tick, then GAP_TICKS s_tick pulses of idle
// guard time are inserted before the next arbitration.
// Optional feature macro: UART_ARB_LOCK_EN (burst lock via req_lock).
// Ports:
//   clk          in  1           system clock
//   reset_n      in  1           synchronous active-low reset
//   s_tick       in  1           baud oversample tick (counted only in GAP)
//   req_valid    in  NREQ        per-requester byte valid
//   req_data     in  NREQ*DBITS  requester i byte at [i*DBITS +: DBITS]
//   req_lock     in  NREQ        per-requester burst lock
//   req_ready    out NREQ        one-hot accept, only in IDLE
//   tx_start     out 1           one-cycle start pulse to uart_tx
//   tx_din       out DBITS       latched byte for uart_tx
//   tx_done_tick in  1           frame-complete pulse from uart_tx
//   busy         out 1           high whenever not IDLE
//   grant_id     out IDW         current or last granted requester
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int DBITS     = DEFAULT_DBITS,
  parameter int GAP_TICKS = 16,
  parameter int IDW       = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_tick,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DBITS-1:0] req_data,
  input  logic [NREQ-1:0]       req_lock,
  output logic [NREQ-1:0]       req_ready,
  output logic                  tx_start,
  output logic [DBITS-1:0]      tx_din,
  input  logic                  tx_done_tick,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id
);

  // A zero-length gap never enters GAP; keep the counter at least one bit.
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  arb_state_t       state, state_next;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant_q;
  logic [DBITS-1:0] din_q;
  logic [GW-1:0]    gap_cnt;

  logic [NREQ-1:0]  pick_grant;
  logic [IDW-1:0]   pick_idx;
  logic             pick_found;
  logic             handshake;
  logic             gap_last;

  logic             lock_en;
  logic [IDW-1:0]   lock_owner;

`ifdef UART_ARB_LOCK_EN
  logic lock_held;

  // The lock only restricts arbitration while the owner keeps req_lock high;
  // the same IDLE cycle it drops, normal round-robin takes over.
  assign lock_en = lock_held & req_lock[lock_owner];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_held  <= 1'b0;
      lock_owner <= '0;
    end else if (state == IDLE) begin
      if (handshake) begin
        lock_held  <= req_lock[pick_idx];
        lock_owner <= pick_idx;
      end else if (lock_held && !req_lock[lock_owner]) begin
        lock_held <= 1'b0;
      end
    end
  end
`else
  logic unused_lock;

  assign lock_en     = 1'b0;
  assign lock_owner  = '0;
  assign unused_lock = ^req_lock;
`endif

  rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .req       (req_valid),
    .last_grant(last_grant),
    .lock_en   (lock_en),
    .lock_owner(lock_owner),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .found     (pick_found)
  );

  // The picker only ever selects a valid requester, so any winner in IDLE
  // completes the handshake this cycle.
  assign handshake = (state == IDLE) && pick_found;
  assign gap_last  = (gap_cnt == GW'(GAP_TICKS - 1));

  assign req_ready = (state == IDLE) ? pick_grant : '0;
  assign tx_start  = (state == START);
  assign busy      = (state != IDLE);
  assign tx_din    = din_q;
  assign grant_id  = grant_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pick_found) state_next = START;
      START:     state_next = WAIT_DONE;
      WAIT_DONE: if (tx_done_tick) state_next = (GAP_TICKS > 0) ? GAP : IDLE;
      GAP:       if (s_tick && gap_last) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      din_q      <= '0;
      grant_q    <= '0;
      last_grant <= IDW'(NREQ - 1);
      gap_cnt    <= '0;
    end else begin
      state <= state_next;
      if (handshake) begin
        din_q      <= req_data[32'(pick_idx) * DBITS +: DBITS];
        grant_q    <= pick_idx;
        last_grant <= pick_idx;
      end
      if ((state == GAP) && s_tick) begin
        gap_cnt <= gap_last ? '0 : gap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (NREQ=3, DBITS=8, GAP_TICKS=2).
// A behavioural model tracks the arbiter as "free / start due / frame in
// flight / guard ticks left" and the round-robin rule, and emulates uart_tx
// by answering each start with tx_done_tick after a random delay.
// Honours UART_ARB_LOCK_EN when compiled with it.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 3;
  localparam int DBITS = 8;
  localparam int GAP   = 2;
  localparam int IDW   = 2;
  localparam int DW    = NREQ * DBITS;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             s_tick;
  logic [NREQ-1:0]  req_valid;
  logic [DW-1:0]    req_data;
  logic [NREQ-1:0]  req_lock;
  logic [NREQ-1:0]  req_ready;
  logic             tx_start;
  logic [DBITS-1:0] tx_din;
  logic             tx_done_tick;
  logic             busy;
  logic [IDW-1:0]   grant_id;

  int checks = 0;
  int errors = 0;

  // model state
  bit               m_start;
  bit               m_wait;
  int               m_gap;
  int               m_last;
  int               m_gid;
  logic [DBITS-1:0] m_din;
  bit               m_lock;
  int               m_owner;
  int               done_delay;
  logic [DBITS-1:0] starts[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ     (NREQ),
    .DBITS    (DBITS),
    .GAP_TICKS(GAP),
    .IDW      (IDW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_tick      (s_tick),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_lock    (req_lock),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_din      (tx_din),
    .tx_done_tick(tx_done_tick),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    m_start    = 1'b0;
    m_wait     = 1'b0;
    m_gap      = 0;
    m_last     = NREQ - 1;
    m_gid      = 0;
    m_din      = '0;
    m_lock     = 1'b0;
    m_owner    = 0;
    done_delay = 0;
  endfunction

  // Round-robin rule: first valid requester after the last winner.
  function automatic int pickWinner(input logic [NREQ-1:0] v, input bit only_owner);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_last + k) % NREQ;
      if (v[i] && (!only_owner || i == m_owner)) return i;
    end
    return -1;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance
  // the model, and step to just after the next rising edge.
  task automatic applyStimulus(input bit rst_n, input logic [NREQ-1:0] v,
                               input logic [DW-1:0] d, input logic [NREQ-1:0] lk,
                               input bit tick, output int hs);
    bit free;
    bit done;
    bit eff_lock;
    int w;
    logic [NREQ-1:0] exp_ready;

    done = m_wait ? (done_delay == 0) : ($urandom_range(0, 9) == 0);
    reset_n      = rst_n;
    req_valid    = v;
    req_data     = d;
    req_lock     = lk;
    s_tick       = tick;
    tx_done_tick = done;
    #1;

    free     = !m_start && !m_wait && (m_gap == 0);
    eff_lock = 1'b0;
`ifdef UART_ARB_LOCK_EN
    eff_lock = m_lock && lk[m_owner];
`endif
    w = free ? pickWinner(v, eff_lock) : -1;
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;

    checkOutput("tx_start", 32'(tx_start), 32'(m_start));
    checkOutput("busy", 32'(busy), 32'(!free));
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("grant_id", 32'(grant_id), 32'(m_gid));
    checkOutput("tx_din", 32'(tx_din), 32'(m_din));

    hs = -1;
    if (!rst_n) begin
      modelReset();
    end else if (free) begin
      if (m_lock && !lk[m_owner]) m_lock = 1'b0;
      if (w >= 0) begin
        hs      = w;
        m_start = 1'b1;
        m_din   = d[w*DBITS +: DBITS];
        m_gid   = w;
        m_last  = w;
        m_lock  = lk[w];
        m_owner = w;
      end
    end else if (m_start) begin
      starts.push_back(m_din);
      m_start    = 1'b0;
      m_wait     = 1'b1;
      done_delay = $urandom_range(0, 5);
    end else if (m_wait) begin
      if (done) begin
        m_wait = 1'b0;
        m_gap  = GAP;
      end else begin
        done_delay--;
      end
    end else if (tick) begin
      m_gap--;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    int hs;
    applyStimulus(1'b0, '0, '0, '0, 1'b0, hs);
    starts.delete();
  endtask

  function automatic bit randTick();
    return ($urandom_range(0, 2) == 0);
  endfunction

  initial begin
    int hs;
    int n;
    int hs1;
    logic [DBITS-1:0] q0[$];
    logic [DBITS-1:0] q1[$];
    logic [DBITS-1:0] exp_seq[4];
    logic [NREQ-1:0] v;
    logic [DW-1:0] d;

    reset_n      = 1'b0;
    s_tick       = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    req_lock     = '0;
    tx_done_tick = 1'b0;
    @(posedge clk);
    #1;
    modelReset();

    // Test 1: all valid, order 10,21,32,10 with gap of 2 ticks.
    doReset();
    n = 0;
    while (starts.size() < 4 && n < 300) begin
      applyStimulus(1'b1, 3'b111, 24'h322110, '0, randTick(), hs);
      n++;
    end
    checkOutput("t1_count", 32'(starts.size() >= 4), 32'd1);
    exp_seq = '{8'h10, 8'h21, 8'h32, 8'h10};
    for (int k = 0; k < 4; k++)
      if (k < starts.size()) checkOutput($sformatf("t1_order%0d", k), 32'(starts[k]), 32'(exp_seq[k]));

    // Test 2: only requester 2 after reset.
    doReset();
    n = 0;
    while (starts.size() < 1 && n < 50) begin
      applyStimulus(1'b1, 3'b100, 24'hA50000, '0, randTick(), hs);
      n++;
    end
    checkOutput("t2_gid", 32'(grant_id), 32'd2);
    checkOutput("t2_started", 32'(starts.size()), 32'd1);
    if (starts.size() > 0) checkOutput("t2_byte", 32'(starts[0]), 32'hA5);
    n = 0;
    while ((m_wait || m_gap > 0) && n < 100) begin
      applyStimulus(1'b1, '0, '0, '0, randTick(), hs);
      n++;
    end

    // Test 3: reset pulse while a frame is in flight.
    doReset();
    n = 0;
    while (!m_wait && n < 20) begin
      applyStimulus(1'b1, 3'b010, 24'h00BB00, '0, 1'b0, hs);
      n++;
    end
    applyStimulus(1'b0, 3'b111, 24'h332211, '0, 1'b1, hs);
    req_valid = 3'b111;
    #1;
    checkOutput("t3_busy", 32'(busy), 32'd0);
    checkOutput("t3_ready", 32'(req_ready), 32'd1);
    applyStimulus(1'b1, 3'b111, 24'h332211, '0, 1'b0, hs);
    checkOutput("t3_hs", 32'(hs), 32'd0);

    // Test 4: requester 1 withdraws while requester 0 is mid-frame.
    doReset();
    hs1 = 0;
    n = 0;
    while (!m_wait && n < 20) begin
      applyStimulus(1'b1, 3'b001, 24'h00005A, '0, 1'b0, hs);
      n++;
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 3'b011, 24'h00775A, '0, 1'b0, hs);
      if (hs == 1) hs1++;
    end
    n = 0;
    while (starts.size() < 2 && n < 100) begin
      applyStimulus(1'b1, 3'b101, 24'hC30000, '0, randTick(), hs);
      if (hs == 1) hs1++;
      n++;
    end
    checkOutput("t4_req1_never", 32'(hs1), 32'd0);
    if (starts.size() >= 2) checkOutput("t4_req2_next", 32'(starts[1]), 32'hC3);
    else checkOutput("t4_started", 32'(starts.size()), 32'd2);

    // Test 5: requester 0 bursts 01,02,03 under req_lock, requester 1 waits.
    doReset();
    q0 = '{8'h01, 8'h02, 8'h03};
    q1 = '{8'h44};
    n = 0;
    while (starts.size() < 4 && n < 400) begin
      v = '0;
      d = '0;
      if (q0.size() > 0) begin v[0] = 1'b1; d[7:0] = q0[0]; end
      if (q1.size() > 0) begin v[1] = 1'b1; d[15:8] = q1[0]; end
      applyStimulus(1'b1, v, d, {2'b00, v[0]}, randTick(), hs);
      if (hs == 0) void'(q0.pop_front());
      if (hs == 1) void'(q1.pop_front());
      n++;
    end
`ifdef UART_ARB_LOCK_EN
    exp_seq = '{8'h01, 8'h02, 8'h03, 8'h44};
`else
    exp_seq = '{8'h01, 8'h44, 8'h02, 8'h03};
`endif
    checkOutput("t5_count", 32'(starts.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < starts.size()) checkOutput($sformatf("t5_order%0d", k), 32'(starts[k]), 32'(exp_seq[k]));

    // Test 6: random traffic, spurious ticks/done pulses, occasional reset.
    doReset();
    for (int c = 0; c < 1500; c++) begin
      v = NREQ'($urandom);
      d = DW'($urandom);
      applyStimulus(($urandom_range(0, 299) != 0), v,  d,
                    ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0,
                    randTick(), hs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
